// File: rtl/snake_pkg.sv
// Shared types for the snake direction scheduler: direction encoding, PS/2 set-2
// scan codes used by the decoder, prefix-FSM states and the reversal rule.
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    PFX_IDLE,
    PFX_BRK,
    PFX_EXT,
    PFX_EXT_BRK
  } pfx_e;

  localparam logic [7:0] SC_BRK     = 8'hF0;
  localparam logic [7:0] SC_EXT     = 8'hE0;
  localparam logic [7:0] SC_UP      = 8'h1D;
  localparam logic [7:0] SC_LEFT    = 8'h1C;
  localparam logic [7:0] SC_DOWN    = 8'h1B;
  localparam logic [7:0] SC_RIGHT   = 8'h23;
  localparam logic [7:0] SC_X_UP    = 8'h75;
  localparam logic [7:0] SC_X_LEFT  = 8'h6B;
  localparam logic [7:0] SC_X_DOWN  = 8'h72;
  localparam logic [7:0] SC_X_RIGHT = 8'h74;
  localparam logic [7:0] SC_ESC     = 8'h76;
  localparam logic [7:0] SC_ENTER   = 8'h5A;

  // Opposite directions differ only in bit 1 of the encoding.
  function automatic dir_e opposite(input dir_e d);
    return dir_e'(d ^ 2'd2);
  endfunction

endpackage

// File: rtl/dir_fifo.sv
// DEPTH x 2-bit direction queue; registered count, head/tail read combinationally.
// Push is refused when full unless a pop happens in the same cycle; flush wins over both.
module dir_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic [1:0]               i_push_dat,
  input  logic                     i_pop,
  output logic [1:0]               o_head,
  output logic [1:0]               o_tail,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [1:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_pop;
  logic          w_do_push;
  logic [AW-1:0] w_tail_ptr;

  assign w_do_pop   = i_pop && (r_count != '0) && !i_flush;
  assign w_do_push  = i_push && ((r_count != FULL_CNT) || w_do_pop) && !i_flush;
  assign w_tail_ptr = r_wr_ptr - AW'(1);

  // When full with a simultaneous pop, the write lands in the slot being read out.
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_dat;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_tail  = r_mem[w_tail_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/snake_dir_scheduler.sv
// Decodes PS/2 set-2 bytes into queued snake direction changes applied one per game tick,
// plus one-shot Esc/Enter pulses; all outputs registered, 1-cycle latency, no backpressure.
module snake_dir_scheduler
  import snake_pkg::*;
#(
  parameter int         DEPTH     = 4,
  parameter logic [1:0] RESET_DIR = 2'd1
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_key_valid,
  input  logic [7:0]               i_key_code,
  input  logic                     i_tick,
  input  logic                     i_flush,
  output logic [1:0]               o_dir,
  output logic                     o_dir_step,
  output logic                     o_esc_pulse,
  output logic                     o_enter_pulse,
  output logic [$clog2(DEPTH):0]   o_q_count,
  output logic                     o_drop
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  pfx_e          r_state;
  pfx_e          w_state_nxt;
  logic          w_make;
  logic          w_brk;
  logic          w_ext;
  logic          w_cand_vld;
  dir_e          w_cand;
  dir_e          w_tail;
  logic          w_accept;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic          w_esc_make;
  logic          w_esc_brk;
  logic          w_enter_make;
  logic          w_enter_brk;
  logic [1:0]    w_fifo_head;
  logic [1:0]    w_fifo_tail;
  logic [CW-1:0] w_fifo_count;

  dir_e r_dir;
  logic r_dir_step;
  logic r_esc_pulse;
  logic r_enter_pulse;
  logic r_esc_held;
  logic r_enter_held;
  logic r_drop;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) r_state <= PFX_IDLE;
    else          r_state <= w_state_nxt;
  end

  // A flush cycle decodes nothing, so every downstream event is suppressed with it.
  always_comb begin
    w_state_nxt = r_state;
    w_make      = 1'b0;
    w_brk       = 1'b0;
    w_ext       = 1'b0;
    if (i_flush) begin
      w_state_nxt = PFX_IDLE;
    end else if (i_key_valid) begin
      case (r_state)
        PFX_IDLE: begin
          if (i_key_code == SC_BRK)      w_state_nxt = PFX_BRK;
          else if (i_key_code == SC_EXT) w_state_nxt = PFX_EXT;
          else                           w_make      = 1'b1;
        end
        PFX_EXT: begin
          if (i_key_code == SC_BRK) begin
            w_state_nxt = PFX_EXT_BRK;
          end else begin
            w_make      = 1'b1;
            w_ext       = 1'b1;
            w_state_nxt = PFX_IDLE;
          end
        end
        PFX_BRK: begin
          w_brk       = 1'b1;
          w_state_nxt = PFX_IDLE;
        end
        PFX_EXT_BRK: begin
          w_brk       = 1'b1;
          w_ext       = 1'b1;
          w_state_nxt = PFX_IDLE;
        end
        default: w_state_nxt = PFX_IDLE;
      endcase
    end
  end

  always_comb begin
    w_cand_vld = 1'b0;
    w_cand     = DIR_UP;
    if (w_make && !w_ext) begin
      case (i_key_code)
        SC_UP:    begin w_cand_vld = 1'b1; w_cand = DIR_UP;    end
        SC_LEFT:  begin w_cand_vld = 1'b1; w_cand = DIR_LEFT;  end
        SC_DOWN:  begin w_cand_vld = 1'b1; w_cand = DIR_DOWN;  end
        SC_RIGHT: begin w_cand_vld = 1'b1; w_cand = DIR_RIGHT; end
        default:  ;
      endcase
    end else if (w_make && w_ext) begin
      case (i_key_code)
        SC_X_UP:    begin w_cand_vld = 1'b1; w_cand = DIR_UP;    end
        SC_X_LEFT:  begin w_cand_vld = 1'b1; w_cand = DIR_LEFT;  end
        SC_X_DOWN:  begin w_cand_vld = 1'b1; w_cand = DIR_DOWN;  end
        SC_X_RIGHT: begin w_cand_vld = 1'b1; w_cand = DIR_RIGHT; end
        default:    ;
      endcase
    end
  end

  // The filter compares against the newest pending move, not the one being popped now.
  assign w_tail   = (w_fifo_count != '0) ? dir_e'(w_fifo_tail) : r_dir;
  assign w_accept = w_cand_vld && (w_cand != w_tail) && (w_cand != opposite(w_tail));
  assign w_full   = (w_fifo_count == FULL_CNT);
  assign w_pop    = i_tick && !i_flush && (w_fifo_count != '0);
  assign w_push   = w_accept && (!w_full || w_pop);
  assign w_drop   = w_accept && w_full && !w_pop;

  assign w_esc_make   = w_make && !w_ext && (i_key_code == SC_ESC);
  assign w_esc_brk    = w_brk  && !w_ext && (i_key_code == SC_ESC);
  assign w_enter_make = w_make && !w_ext && (i_key_code == SC_ENTER);
  assign w_enter_brk  = w_brk  && !w_ext && (i_key_code == SC_ENTER);

  dir_fifo #(
    .DEPTH (DEPTH)
  ) u_dir_fifo (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_flush    (i_flush),
    .i_push     (w_push),
    .i_push_dat (w_cand),
    .i_pop      (w_pop),
    .o_head     (w_fifo_head),
    .o_tail     (w_fifo_tail),
    .o_count    (w_fifo_count)
  );

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_dir         <= dir_e'(RESET_DIR);
      r_dir_step    <= 1'b0;
      r_esc_pulse   <= 1'b0;
      r_enter_pulse <= 1'b0;
      r_esc_held    <= 1'b0;
      r_enter_held  <= 1'b0;
      r_drop        <= 1'b0;
    end else begin
      r_dir_step    <= w_pop;
      r_drop        <= w_drop;
      r_esc_pulse   <= w_esc_make && !r_esc_held;
      r_enter_pulse <= w_enter_make && !r_enter_held;
      if (i_flush)    r_dir <= dir_e'(RESET_DIR);
      else if (w_pop) r_dir <= dir_e'(w_fifo_head);
      if (i_flush)         r_esc_held <= 1'b0;
      else if (w_esc_make) r_esc_held <= 1'b1;
      else if (w_esc_brk)  r_esc_held <= 1'b0;
      if (i_flush)           r_enter_held <= 1'b0;
      else if (w_enter_make) r_enter_held <= 1'b1;
      else if (w_enter_brk)  r_enter_held <= 1'b0;
    end
  end

  assign o_dir         = r_dir;
  assign o_dir_step    = r_dir_step;
  assign o_esc_pulse   = r_esc_pulse;
  assign o_enter_pulse = r_enter_pulse;
  assign o_q_count     = w_fifo_count;
  assign o_drop        = r_drop;

endmodule
